// File: rtl/imem_loader_pkg.sv
// Shared instruction-memory constants, loader state encoding and word layout.
// Imported by the loader, its bus interface and the instruction memory.
package imem_loader_pkg;

  localparam int unsigned COL         = 16;
  localparam int unsigned ROW_I       = 15;
  localparam int unsigned IMEM_ADDR_W = 4;
  localparam int unsigned BYTE_W      = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_HI    = 3'd2;
  localparam logic [2:0] S_LO    = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  typedef struct packed {
    logic [BYTE_W-1:0] hi;
    logic [BYTE_W-1:0] lo;
  } instr_word_t;

  // A length header is usable when it names between 1 and the number of memory rows.
  function automatic logic len_ok(input logic [BYTE_W-1:0] n, input int unsigned words);
    return (n != '0) && (32'(n) <= words);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream, instruction-memory write and CPU-hold signals of the loader.
// The host side uses master; the loader itself uses slave.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W
);

  logic              start;
  logic [BYTE_W-1:0] byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [COL-1:0]    mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err
  );

endinterface

// File: rtl/imem_loader.sv
// Serial program loader: takes a length byte then hi/lo byte pairs and writes
// each assembled 16-bit word into the instruction memory while the CPU is held.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned WORDS  = ROW_I,
  parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus
);

  localparam int unsigned LEN_W = ADDR_W + 1;

  logic [2:0]        state_q,     state_d;
  logic [ADDR_W-1:0] cnt_q,       cnt_d;
  logic [LEN_W-1:0]  len_q,       len_d;
  logic [BYTE_W-1:0] hi_q,        hi_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  instr_word_t       mem_wdata_q, mem_wdata_d;
  logic              busy_q,      busy_d;
  logic              cpu_hold_q,  cpu_hold_d;
  logic              done_q,      done_d;
  logic              err_q,       err_d;

  logic byte_ready_c;
  logic xfer_c;
  logic last_word_c;

  // Ready is a pure state decode so the byte source sees no combinational path back.
  assign byte_ready_c = (state_q == S_LEN) || (state_q == S_HI) || (state_q == S_LO);
  assign xfer_c       = bus.byte_valid && byte_ready_c;
  assign last_word_c  = ({1'b0, cnt_q} == (len_q - LEN_W'(1)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    hi_d        = hi_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE, S_ERR: begin
        if (bus.start) state_d = S_LEN;
      end
      S_LEN: begin
        if (xfer_c) begin
          if (len_ok(bus.byte_in, WORDS)) begin
            len_d   = LEN_W'(bus.byte_in);
            cnt_d   = '0;
            state_d = S_HI;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_HI: begin
        if (xfer_c) begin
          hi_d    = bus.byte_in;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (xfer_c) begin
          mem_wdata_d = '{hi: hi_q, lo: bus.byte_in};
          mem_addr_d  = cnt_q;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        if (last_word_c) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + ADDR_W'(1);
          state_d = S_HI;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status flops are loaded from the next state so they line up with it.
    mem_we_d   = (state_d == S_WRITE);
    busy_d     = (state_d == S_LEN) || (state_d == S_HI) || (state_d == S_LO) ||
                 (state_d == S_WRITE) || (state_d == S_DONE);
    cpu_hold_d = busy_d;
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      hi_q        <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      cpu_hold_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      hi_q        <= hi_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.byte_ready = byte_ready_c;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.busy       = busy_q;
  assign bus.cpu_hold   = cpu_hold_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: byte streams are turned into expected writes, done
// pulses and status levels by a stream-level model and checked every cycle.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int unsigned WORDS = ROW_I;
  localparam int unsigned AW    = IMEM_ADDR_W;
  localparam int unsigned DEPTH = 1 << AW;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    time           t;
  } wr_t;

  logic clk = 1'b0;
  logic reset;

  imem_loader_if #(.ADDR_W(AW)) bus ();

  imem_loader #(.WORDS(WORDS), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  wr_t           exp_wq[$];
  time           exp_dq[$];
  logic [15:0]   ref_mem[DEPTH];
  logic [15:0]   cap_mem[DEPTH];
  logic          exp_err  = 1'b0;
  logic          exp_busy = 1'b0;
  int            wr_count = 0;
  logic          prev_we  = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [15:0]   last_data = '0;
  wr_t           cur_wr;
  time           cur_dt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the stream model.
  always @(negedge clk) begin
    if (reset) begin
      prev_we   = 1'b0;
      last_addr = '0;
      last_data = '0;
    end else begin
      if (bus.mem_we) begin
        if (exp_wq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr %0h data %0h, expected no write at t=%0t",
                   bus.mem_addr, bus.mem_wdata, $time);
        end else begin
          cur_wr = exp_wq.pop_front();
          chk("wr_addr", 32'(bus.mem_addr), 32'(cur_wr.addr));
          chk("wr_data", 32'(bus.mem_wdata), 32'(cur_wr.data));
          chk("wr_time", 32'($time), 32'(cur_wr.t));
        end
        chk("we_width", 32'(prev_we), 32'(0));
        cap_mem[bus.mem_addr] = bus.mem_wdata;
        wr_count++;
        last_addr = bus.mem_addr;
        last_data = bus.mem_wdata;
      end else begin
        chk("addr_hold", 32'(bus.mem_addr), 32'(last_addr));
        chk("wdata_hold", 32'(bus.mem_wdata), 32'(last_data));
      end
      if (bus.done) begin
        if (exp_dq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1, expected 0 at t=%0t", $time);
        end else begin
          cur_dt = exp_dq.pop_front();
          chk("done_time", 32'($time), 32'(cur_dt));
        end
      end
      chk("err", 32'(bus.err), 32'(exp_err));
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      chk("cpu_hold", 32'(bus.cpu_hold), 32'(exp_busy));
      if (bus.byte_ready) chk("ready_only_when_busy", 32'(bus.busy), 32'(1));
      if (bus.done) exp_busy = 1'b0;
      prev_we = bus.mem_we;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    exp_busy = 1'b1;
    exp_err  = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Returns on the rising edge at which the byte transfers.
  task automatic send_byte(input logic [7:0] b, input int gap, output time acc_t);
    int n;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    n = 0;
    while (!bus.byte_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.byte_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got byte_ready=0 for %0d cycles, expected 1", n);
      bus.byte_valid = 1'b0;
      acc_t = 0;
    end else begin
      @(posedge clk);
      acc_t = $time;
    end
  endtask

  task automatic check_mem();
    for (int k = 0; k < int'(DEPTH); k++) chk("mem_content", 32'(cap_mem[k]), 32'(ref_mem[k]));
  endtask

  task automatic run_load(input logic [7:0] bytes[$], input int gap_max, input bit start_in_hi,
                          input int stall_idx, input int abort_word);
    time  t;
    int   n;
    int   g;
    int   w;
    wr_t  wr;
    pulse_start();
    n = int'(bytes[0]);
    send_byte(bytes[0], 0, t);
    if (n == 0 || n > int'(WORDS)) begin
      exp_err  = 1'b1;
      exp_busy = 1'b0;
      @(negedge clk);
      bus.byte_valid = 1'b0;
      #1;
      chk("err_ready", 32'(bus.byte_ready), 32'(0));
      return;
    end
    if (start_in_hi) begin
      @(negedge clk);
      bus.byte_valid = 1'b0;
      bus.start      = 1'b1;
      @(negedge clk);
      bus.start      = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      for (int j = 1; j <= 2; j++) begin
        g = (2 * i + j == stall_idx) ? 100 : int'($urandom_range(gap_max, 0));
        send_byte(bytes[2 * i + j], g, t);
      end
      if (i == abort_word) begin
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mem_we", 32'(bus.mem_we), 32'(0));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_cpu_hold", 32'(bus.cpu_hold), 32'(0));
        chk("rst_done", 32'(bus.done), 32'(0));
        chk("rst_err", 32'(bus.err), 32'(0));
        chk("rst_ready", 32'(bus.byte_ready), 32'(0));
        chk("rst_addr", 32'(bus.mem_addr), 32'(0));
        chk("rst_wdata", 32'(bus.mem_wdata), 32'(0));
        bus.byte_valid = 1'b0;
        exp_wq.delete();
        exp_dq.delete();
        exp_busy = 1'b0;
        exp_err  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        return;
      end
      w = 2 * i + 1;
      ref_mem[i] = {bytes[w], bytes[w + 1]};
      wr.addr = AW'(i);
      wr.data = ref_mem[i];
      wr.t    = t + 5;
      exp_wq.push_back(wr);
      if (i == n - 1) exp_dq.push_back(t + 15);
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
    #1;
    g = 0;
    while ((exp_wq.size() != 0 || exp_dq.size() != 0) && g < 50) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk("drained", 32'(exp_wq.size() + exp_dq.size()), 32'(0));
    @(negedge clk);
    #1;
    chk("idle_busy", 32'(bus.busy), 32'(0));
    chk("idle_cpu_hold", 32'(bus.cpu_hold), 32'(0));
  endtask

  task automatic random_load(input int n, input int gap_max, input bit start_in_hi,
                             input int stall_idx, input int abort_word);
    logic [7:0] q[$];
    q.push_back(8'(n));
    for (int k = 0; k < 2 * n; k++) q.push_back(8'($urandom_range(255, 0)));
    run_load(q, gap_max, start_in_hi, stall_idx, abort_word);
  endtask

  initial begin
    logic [7:0] q[$];
    for (int k = 0; k < int'(DEPTH); k++) begin
      ref_mem[k] = '0;
      cap_mem[k] = '0;
    end
    bus.start      = 1'b0;
    bus.byte_in    = '0;
    bus.byte_valid = 1'b0;
    reset          = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("init_mem_we", 32'(bus.mem_we), 32'(0));
    chk("init_busy", 32'(bus.busy), 32'(0));
    chk("init_cpu_hold", 32'(bus.cpu_hold), 32'(0));
    chk("init_done", 32'(bus.done), 32'(0));
    chk("init_err", 32'(bus.err), 32'(0));
    chk("init_ready", 32'(bus.byte_ready), 32'(0));
    chk("init_addr", 32'(bus.mem_addr), 32'(0));
    chk("init_wdata", 32'(bus.mem_wdata), 32'(0));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Two back-to-back words.
    q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    run_load(q, 0, 1'b0, -1, -1);
    chk("lit_addr0", 32'(cap_mem[0]), 32'h1234);
    chk("lit_addr1", 32'(cap_mem[1]), 32'hABCD);
    chk("lit_wr_count_a", 32'(wr_count), 32'd2);

    // Bad headers, then recovery from ERR.
    q = '{8'h00};
    run_load(q, 0, 1'b0, -1, -1);
    chk("lit_err_zero", 32'(bus.err), 32'd1);
    q = '{8'h10};
    run_load(q, 0, 1'b0, -1, -1);
    chk("lit_err_16", 32'(bus.err), 32'd1);
    chk("lit_wr_count_b", 32'(wr_count), 32'd2);
    q = '{8'h01, 8'hFF, 8'h00};
    run_load(q, 0, 1'b0, -1, -1);
    chk("lit_err_clear", 32'(bus.err), 32'd0);
    chk("lit_ff00", 32'(cap_mem[0]), 32'hFF00);
    chk("lit_wr_count_c", 32'(wr_count), 32'd3);
    check_mem();

    // Full memory with random gaps.
    random_load(15, 3, 1'b0, -1, -1);
    chk("lit_wr_count_d", 32'(wr_count), 32'd18);
    check_mem();

    // Start pulsed while waiting for a hi byte.
    random_load(int'($urandom_range(15, 1)), 2, 1'b1, -1, -1);
    check_mem();

    // Long stall in LO on the second word.
    random_load(3, 0, 1'b0, 4, -1);
    check_mem();

    // Random-length loads.
    for (int r = 0; r < 4; r++) begin
      random_load(int'($urandom_range(15, 1)), 2, 1'b0, -1, -1);
      check_mem();
    end

    // Asynchronous reset while word 3 is being written.
    random_load(6, 0, 1'b0, -1, 3);
    repeat (2) @(negedge clk);
    check_mem();

    // Loader recovers after the aborted load.
    random_load(2, 1, 1'b0, -1, -1);
    check_mem();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
